// File: rtl/ram_clr.sv
// rtl/ram_clr.sv - parametrised single-port RAM with registered read and post-reset clear sequencer
module ram_clr #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      ram_out,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_addr;

    // The last clear write lands on the all-ones address; no compare against DEPTH is needed.
    logic clr_last;
    assign clr_last = &clr_addr;

    // Memory array: zero fill while clearing, user writes once ready; reset leaves contents alone.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (load) begin
                mem[address] <= data_in;
            end
        end
    end

    // Control and read port: clear sequencing, busy flag, registered read with write-first bypass.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            ram_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    out_valid <= 1'b0;
                    if (clr_last) begin
                        // Stop on the last address so the counter never starts a second pass.
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    if (read_en) begin
                        // Same-edge write wins: return the incoming data, not the stale word.
                        ram_out   <= load ? data_in : mem[address];
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_clr.sv
// tb/tb_ram_clr.sv - scoreboard bench for ram_clr at default and small parameters
module tb_ram_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        a_rst = 1'b0, a_load = 1'b0, a_rd = 1'b0;
    logic [5:0]  a_addr = '0;
    logic [15:0] a_din = '0, a_out;
    logic        a_valid, a_busy;

    // WIDTH=8, ADDR_WIDTH=3 instance
    logic        b_rst = 1'b0, b_load = 1'b0, b_rd = 1'b0;
    logic [2:0]  b_addr = '0;
    logic [7:0]  b_din = '0, b_out;
    logic        b_valid, b_busy;

    ram_clr dut_a (
        .clk(clk), .reset_n(a_rst), .load(a_load), .read_en(a_rd),
        .address(a_addr), .data_in(a_din), .ram_out(a_out),
        .out_valid(a_valid), .busy(a_busy)
    );

    ram_clr #(.WIDTH(8), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .reset_n(b_rst), .load(b_load), .read_en(b_rd),
        .address(b_addr), .data_in(b_din), .ram_out(b_out),
        .out_valid(b_valid), .busy(b_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] qa[$];
    logic [7:0]  qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid must match the oldest expected read result.
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_valid", {31'd0, a_valid}, 32'd0);
            else check("a_read_data", {16'd0, a_out}, {16'd0, qa.pop_front()});
        end
        if (b_valid === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_valid", {31'd0, b_valid}, 32'd0);
            else check("b_read_data", {24'd0, b_out}, {24'd0, qb.pop_front()});
        end
    end

    task automatic a_write(input logic [5:0] addr, input logic [15:0] d);
        a_addr = addr; a_din = d; a_load = 1'b1;
        tick();
        a_load = 1'b0;
    endtask

    task automatic a_read(input logic [5:0] addr, input logic [15:0] exp);
        a_addr = addr; a_rd = 1'b1;
        qa.push_back(exp);
        tick();
        a_rd = 1'b0;
    endtask

    // Release reset with hostile commands held (address 3 <- FFFF, read) and count busy edges.
    task automatic a_clear(input int exp_len);
        int n;
        a_rst = 1'b1; a_load = 1'b1; a_rd = 1'b1; a_addr = 6'd3; a_din = 16'hFFFF;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy === 1'b1 && n < 200);
        a_load = 1'b0; a_rd = 1'b0;
        check("a_busy_len", n, exp_len);
        check("a_out_after_clear", {16'd0, a_out}, 32'd0);
    endtask

    task automatic a_reset_pulse();
        a_rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        // reset held for two edges
        tick();
        tick();
        check("a_reset_busy", {31'd0, a_busy}, 32'd1);
        check("a_reset_out", {16'd0, a_out}, 32'd0);
        check("a_reset_valid", {31'd0, a_valid}, 32'd0);

        a_clear(64);
        for (int i = 0; i < 64; i++) a_read(i[5:0], 16'h0000);
        tick();

        // write/read
        a_write(6'd5, 16'hBEEF);
        a_write(6'd63, 16'h1234);
        a_read(6'd5, 16'hBEEF);
        a_read(6'd63, 16'h1234);
        tick();
        check("a_valid_drops", {31'd0, a_valid}, 32'd0);

        // write-first
        a_write(6'd9, 16'h0001);
        a_addr = 6'd9; a_din = 16'hA5A5; a_load = 1'b1; a_rd = 1'b1;
        qa.push_back(16'hA5A5);
        tick();
        a_load = 1'b0; a_rd = 1'b0;
        a_read(6'd9, 16'hA5A5);
        tick();

        // reset at clear cycle 10
        a_write(6'd2, 16'h7777);
        a_read(6'd2, 16'h7777);
        a_reset_pulse();
        a_rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("a_busy_mid_clear", {31'd0, a_busy}, 32'd1);
        a_reset_pulse();
        a_clear(64);
        a_read(6'd2, 16'h0000);

        // reset while ready; command on the reset edge is discarded
        a_write(6'd2, 16'h7777);
        a_addr = 6'd2; a_din = 16'h1111; a_load = 1'b1; a_rd = 1'b1; a_rst = 1'b0;
        tick();
        a_load = 1'b0; a_rd = 1'b0;
        check("a_reset_ready_busy", {31'd0, a_busy}, 32'd1);
        a_clear(64);
        a_read(6'd2, 16'h0000);
        a_read(6'd3, 16'h0000);
        tick();

        // alternate parameters
        tick();
        b_rst = 1'b1; b_load = 1'b1; b_rd = 1'b1; b_addr = 3'd3; b_din = 8'hFF;
        n = 0;
        do begin
            tick();
            n++;
        end while (b_busy === 1'b1 && n < 50);
        b_load = 1'b0; b_rd = 1'b0;
        check("b_busy_len", n, 8);
        b_addr = 3'd7; b_din = 8'hC3; b_load = 1'b1;
        tick();
        b_load = 1'b0;
        b_addr = 3'd7; b_rd = 1'b1; qb.push_back(8'hC3);
        tick();
        b_addr = 3'd0; qb.push_back(8'h00);
        tick();
        b_addr = 3'd3; qb.push_back(8'h00);
        tick();
        b_rd = 1'b0;
        tick();
        tick();

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_clr.md
# ram_clr

Parametrised single-port synchronous RAM; successor to the fixed 16-bit RAM8/RAM64 stack, generalised in word width and depth. Adds a registered read port with a valid strobe, write-first read-during-write, and a hardware clear sequencer that zeroes every word after reset. Sits between the CPU datapath and the memory map as the general data-memory primitive.

## Interface
- WIDTH, 16, data word width in bits (>=1)
- ADDR_WIDTH, 6, address width; DEPTH = 2^ADDR_WIDTH words (>=1)

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- load  in  1  write strobe; writes data_in to address at the clock edge
- read_en  in  1  read strobe; captures the word at address into ram_out
- address  in  ADDR_WIDTH  word address for read and write
- data_in  in  WIDTH  write data
- ram_out  out  WIDTH  registered read data; holds its value between reads
- out_valid  out  1  one-cycle pulse: ram_out updated by a read this cycle
- busy  out  1  clear sequence in progress; commands ignored while high

## Operation
- Two states: CLEAR and READY. A clear counter, clr_addr, is ADDR_WIDTH bits wide.
- Reset: any edge with reset_n=0 sets state=CLEAR, clr_addr=0, ram_out=0, out_valid=0, busy=1. Memory contents are not touched during reset. It is then zeroed by CLEAR.
- CLEAR: at each edge with reset_n=1, write 0 to mem[clr_addr] and increment clr_addr.
  - On the edge that writes clr_addr=DEPTH-1, go to READY and set busy=0.
  - The counter must not wrap into a second pass.
  - load and read_en are ignored; ram_out holds 0 and out_valid stays 0.
- READY, write: at an edge with load=1, mem[address] <= data_in.
- READY, read: at an edge with read_en=1, ram_out <= mem[address] and out_valid <= 1. At any edge with read_en=0, out_valid <= 0 and ram_out holds its value.
- Simultaneous load=1 and read_en=1 (same address by construction): write-first. ram_out <= data_in, and memory is updated with data_in.
- Address range: all values 0..DEPTH-1 are valid. There is no out-of-range case, and no wrap logic on the user port.
- Reset mid-CLEAR or mid-READY: the sequence restarts from clr_addr=0 and the full DEPTH-cycle clear repeats. A read or write on the same edge as reset_n=0 is discarded.

## Timing
- Let E0 be the first rising edge sampled with reset_n=1 after reset.
- Zero writes go to addresses 0..DEPTH-1 on edges E0..E0+DEPTH-1.
- busy is 1 from the first reset edge through edge E0+DEPTH-1, and 0 after it.
- The first accepted command is sampled at edge E0+DEPTH. For the default parameters (DEPTH=64), that is 64 cycles after reset release.
- Write latency: data is visible to a read sampled on the next edge.
- Read latency: 1 cycle. ram_out and out_valid change together, immediately after the sampling edge.
- Back-to-back reads on consecutive edges give one result per cycle, and out_valid stays high continuously.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset/clear, default parameters:
  - Stimulus: hold reset_n=0 for 2 cycles, then release; read all 64 addresses once busy=0.
  - Response: busy is high for exactly 64 edges after release; every ram_out = 0x0000 with out_valid=1.
- Write/read:
  - Stimulus: write 0xBEEF to address 5 and 0x1234 to address 63, then read address 5, then address 63.
  - Response: ram_out = 0xBEEF, then 0x1234, each 1 cycle after its read edge; out_valid is high for exactly those 2 cycles.
- Write-first:
  - Stimulus: address 9 holds 0x0001; assert load=1 and read_en=1 together at address 9 with data_in=0xA5A5.
  - Response: ram_out = 0xA5A5; a following read of address 9 also returns 0xA5A5.
- Busy lockout:
  - Stimulus: during CLEAR, drive load=1 at address 3 with data_in=0xFFFF, and read_en=1.
  - Response: out_valid stays 0; after clear completes, address 3 reads 0x0000.
- Reset mid-operation:
  - Stimulus: write 0x7777 to address 2, pulse reset_n=0 for one edge at clear cycle 10, then later at READY.
  - Response: each reset restarts the clear with a full 64 busy cycles; address 2 then reads 0x0000.
- Alternate parameters:
  - Stimulus: WIDTH=8, ADDR_WIDTH=3; write 0xC3 to address 7, then read it.
  - Response: busy lasts exactly 8 cycles; ram_out = 0xC3; address 0 reads 0x00.
